traffic_phase_ctrl: RTL and testbench

- Phase controller directly upstream of the countdown timer: sequences main-road lights GREEN -> YELLOW -> RED -> GREEN.
- Drives the timer's `current_state` and `load` inputs and consumes its `zero` flag and `timer` count.
- Adds a latched pedestrian request with a walk signal during RED, and a night mode in which the yellow lamp flashes.
- Sits between the board-level inputs (button, mode switch) and the lamp drivers.

---
 rtl/traffic_phase_ctrl_pkg.sv | 35 +++
 rtl/traffic_phase_ctrl_ped_latch.sv | 37 +++
 rtl/traffic_phase_ctrl.sv | 93 +++++++++
 tb/tb_traffic_phase_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
// Phase encodings and timing constants shared between the phase controller and
// the countdown timer, plus the controller's internal state set.
package traffic_phase_ctrl_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_RED    = 2'b10
  } phase_t;

  localparam logic [PHASE_W-1:0] YELLOW_CODE = PH_YELLOW;

  // Load-to-blank window; covers the stale zero the registered timer shows after reload
  localparam int                 BLANK_W      = 2;
  localparam logic [BLANK_W-1:0] BLANK_CYCLES = 2'd2;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_RED    = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  function automatic logic [PHASE_W-1:0] phase_code(input state_t s);
    case (s)
      ST_GREEN:  return PH_GREEN;
      ST_YELLOW: return YELLOW_CODE;
      ST_RED:    return PH_RED;
      default:   return YELLOW_CODE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_ped_latch.sv
// Pedestrian request latch: holds a button press until the next entry into RED,
// then converts it into a walk grant with a one-cycle acknowledge.
module traffic_phase_ctrl_ped_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic ped_req,
  input  logic in_red,
  input  logic enter_red,
  input  logic leave_red,
  output logic walk_grant,
  output logic ped_ack
);

  logic ped_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      walk_grant  <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      ped_ack <= 1'b0;
      // A press coinciding with the grant edge is absorbed by that grant
      if (enter_red && ped_pending) begin
        walk_grant  <= 1'b1;
        ped_pending <= 1'b0;
        ped_ack     <= 1'b1;
      end else begin
        if (leave_red)
          walk_grant <= 1'b0;
        if (ped_req && !(in_red && walk_grant))
          ped_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Main-road phase sequencer in front of the countdown timer: GREEN -> YELLOW ->
// RED -> GREEN, with a flashing-yellow night mode and pedestrian walk during RED.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_GREEN  | main road green, timer running GREEN time
// ST_YELLOW | main road yellow, timer running YELLOW time
// ST_RED    | main road red; walk lamp allowed if a request was granted
// ST_FLASH  | night mode, yellow toggles on every yellow-time expiry
module traffic_phase_ctrl #(
  parameter logic [31:0] PED_CLEAR = 32'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        zero,
  input  logic [31:0] timer_value,
  input  logic        ped_req,
  input  logic        night_mode,
  output logic [1:0]  current_state,
  output logic        load,
  output logic        main_green,
  output logic        main_yellow,
  output logic        main_red,
  output logic        ped_walk,
  output logic        ped_ack,
  output logic        night_active
);

  import traffic_phase_ctrl_pkg::*;

  state_t             state;
  state_t             next_state;
  logic [BLANK_W-1:0] blank;
  logic               flash_on;
  logic               accept;
  logic               walk_grant;

  assign accept = zero && (blank == '0) && !load;

  always_comb begin
    next_state = state;
    if (night_mode)
      next_state = ST_FLASH;
    else begin
      case (state)
        ST_GREEN:  next_state = ST_YELLOW;
        ST_YELLOW: next_state = ST_RED;
        ST_RED:    next_state = ST_GREEN;
        default:   next_state = ST_RED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_GREEN;
      current_state <= PH_GREEN;
      load          <= 1'b0;
      blank         <= '0;
      flash_on      <= 1'b1;
    end else begin
      load <= 1'b0;
      if (accept) begin
        state         <= next_state;
        current_state <= phase_code(next_state);
        load          <= 1'b1;
        blank         <= BLANK_CYCLES;
        flash_on      <= (state == ST_FLASH && next_state == ST_FLASH) ? !flash_on : 1'b1;
      end else if (!load && blank != '0) begin
        blank <= blank - BLANK_W'(1);
      end
    end
  end

  traffic_phase_ctrl_ped_latch u_ped_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .ped_req    (ped_req),
    .in_red     (state == ST_RED),
    .enter_red  (accept && next_state == ST_RED),
    .leave_red  (accept && state == ST_RED),
    .walk_grant (walk_grant),
    .ped_ack    (ped_ack)
  );

  assign main_green   = (state == ST_GREEN);
  assign main_yellow  = (state == ST_YELLOW) || (state == ST_FLASH && flash_on);
  assign main_red     = (state == ST_RED);
  assign night_active = (state == ST_FLASH);
  assign ped_walk     = (state == ST_RED) && walk_grant && (blank == '0) && !load &&
                        (timer_value > PED_CLEAR);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Phase controller paired with a behavioural countdown timer (GREEN 15 /
// YELLOW 3 / RED 18); expected events are queued and matched by a monitor.
module tb_traffic_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        zero;
  logic [31:0] timer_value;
  logic        ped_req;
  logic        night_mode;
  logic [1:0]  current_state;
  logic        load;
  logic        main_green, main_yellow, main_red;
  logic        ped_walk, ped_ack, night_active;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .zero          (zero),
    .timer_value   (timer_value),
    .ped_req       (ped_req),
    .night_mode    (night_mode),
    .current_state (current_state),
    .load          (load),
    .main_green    (main_green),
    .main_yellow   (main_yellow),
    .main_red      (main_red),
    .ped_walk      (ped_walk),
    .ped_ack       (ped_ack),
    .night_active  (night_active)
  );

  // Countdown timer: reloads on load, holds at 0, zero flag registered one cycle late
  function automatic logic [31:0] dur(input logic [1:0] cs);
    case (cs)
      2'b01:   return 32'd3;
      2'b10:   return 32'd18;
      default: return 32'd15;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_value <= 32'd15;
      zero        <= 1'b0;
    end else begin
      zero <= (timer_value == 32'd0);
      if (load)
        timer_value <= dur(current_state);
      else if (timer_value != 32'd0)
        timer_value <= timer_value - 32'd1;
    end
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  localparam int K_PHASE = 0, K_ACK = 1, K_RISE = 2, K_FALL = 3;
  // {current_state, green, yellow, red, night_active}
  localparam int P_G    = 6'b001000;
  localparam int P_Y    = 6'b010100;
  localparam int P_R    = 6'b100010;
  localparam int P_FON  = 6'b010101;
  localparam int P_FOFF = 6'b010001;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  logic walk_q;

  function automatic string kname(input int k);
    case (k)
      K_PHASE: return "phase_load";
      K_ACK:   return "ped_ack";
      K_RISE:  return "walk_rise";
      default: return "walk_fall";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s: got cyc=%0d val=%0h, required no event", kname(kind), cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        n_errors++;
        $display("FAIL %s: got %s cyc=%0d val=%0h, required %s cyc=%0d val=%0h",
                 kname(e.kind), kname(kind), cyc, val, kname(e.kind), e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (load)
        observe(K_PHASE, int'({current_state, main_green, main_yellow, main_red, night_active}));
      if (ped_ack)
        observe(K_ACK, int'(current_state));
      if (ped_walk !== walk_q)
        observe(ped_walk ? K_RISE : K_FALL, int'(timer_value));
      walk_q = ped_walk;
    end else begin
      walk_q = 1'b0;
    end
  end

  task automatic chk(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_cyc: got cyc=%0d, required %0d", cyc, n);
    end
    #2;
  endtask

  task automatic pulse_req(input int n);
    at_cyc(n - 1);
    ped_req = 1'b1;
    at_cyc(n);
    ped_req = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst_n      = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    #1;
    chk(name, int'({current_state, load, main_green, main_yellow, main_red,
                    ped_walk, ped_ack, night_active}), 9'b000100000);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic end_scen(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic expect_ped_cycle();
    expect_ev(K_PHASE, 17, P_Y);
    expect_ev(K_PHASE, 23, P_R);
    expect_ev(K_ACK,   23, 2);
    expect_ev(K_RISE,  26, 16);
    expect_ev(K_FALL,  37, 5);
    expect_ev(K_PHASE, 44, P_G);
    expect_ev(K_PHASE, 62, P_Y);
    expect_ev(K_PHASE, 68, P_R);
  endtask

  initial begin
    rst_n      = 1'b1;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    #3;

    // plain sequence
    do_reset("reset_s1");
    expect_ev(K_PHASE, 17, P_Y);
    expect_ev(K_PHASE, 23, P_R);
    expect_ev(K_PHASE, 44, P_G);
    at_cyc(50);
    end_scen("leftover_s1");

    // request at cycle 5, granted at RED entry; next RED without walk
    do_reset("reset_s2");
    expect_ped_cycle();
    pulse_req(5);
    at_cyc(80);
    end_scen("leftover_s2");

    // extra press during granted RED is dropped
    do_reset("reset_s3");
    expect_ped_cycle();
    expect_ev(K_PHASE, 89, P_G);
    pulse_req(5);
    pulse_req(30);
    at_cyc(92);
    end_scen("leftover_s3");

    // press on the grant edge is absorbed
    do_reset("reset_s4");
    expect_ped_cycle();
    pulse_req(5);
    pulse_req(23);
    at_cyc(80);
    end_scen("leftover_s4");

    // night mode, press held through FLASH, exit to RED
    do_reset("reset_s5");
    expect_ev(K_PHASE, 17, P_FON);
    expect_ev(K_PHASE, 23, P_FOFF);
    expect_ev(K_PHASE, 29, P_FON);
    expect_ev(K_PHASE, 35, P_FOFF);
    expect_ev(K_PHASE, 41, P_R);
    expect_ev(K_ACK,   41, 2);
    expect_ev(K_RISE,  44, 16);
    expect_ev(K_FALL,  55, 5);
    expect_ev(K_PHASE, 62, P_G);
    at_cyc(2);
    night_mode = 1'b1;
    pulse_req(20);
    at_cyc(36);
    night_mode = 1'b0;
    at_cyc(64);
    end_scen("leftover_s5");

    // reset mid-YELLOW drops the pending request and restarts the sequence
    do_reset("reset_s6");
    expect_ev(K_PHASE, 17, P_Y);
    pulse_req(5);
    at_cyc(20);
    end_scen("leftover_s6a");
    do_reset("reset_mid_yellow");
    expect_ev(K_PHASE, 17, P_Y);
    expect_ev(K_PHASE, 23, P_R);
    expect_ev(K_PHASE, 44, P_G);
    at_cyc(50);
    end_scen("leftover_s6b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
